// File: rtl/cp0_unit.sv
// rtl/cp0_unit.sv - coprocessor-0 exception/interrupt controller (SR, Cause, EPC, PRId)
module cp0_unit #(
    parameter logic [31:0] PRID = 32'h2023_0001
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        En,
    input  logic [4:0]  CP0Addr,
    input  logic [31:0] CP0In,
    output logic [31:0] CP0Out,
    input  logic [31:0] VPC,
    input  logic        BDIn,
    input  logic [4:0]  ExcCodeIn,
    input  logic [5:0]  HWInt,
    input  logic        EXLClr,
    output logic [31:0] EPCOut,
    output logic        Req
);

    logic [5:0]  r_im;
    logic        r_exl;
    logic        r_ie;
    logic        r_bd;
    logic [5:0]  r_ip;
    logic [4:0]  r_exccode;
    logic [31:0] r_epc;

    logic        w_int_req;
    logic        w_exc_req;
    logic [31:0] w_vpc_aligned;
    logic [31:0] w_epc_next;
    logic        w_unused_bits;

    assign w_int_req     = r_ie & ~r_exl & (|(HWInt & r_im));
    assign w_exc_req     = ~r_exl & (ExcCodeIn != 5'd0);
    assign Req           = w_int_req | w_exc_req;
    assign w_vpc_aligned = {VPC[31:2], 2'b00};
    // Delay-slot faults restart at the branch so it is re-executed.
    assign w_epc_next    = BDIn ? (w_vpc_aligned - 32'd4) : w_vpc_aligned;
    assign EPCOut        = r_epc;
    assign w_unused_bits = ^{CP0In[31:16], CP0In[9:2], VPC[1:0]};

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_im      <= 6'd0;
            r_exl     <= 1'b0;
            r_ie      <= 1'b0;
            r_bd      <= 1'b0;
            r_ip      <= 6'd0;
            r_exccode <= 5'd0;
            r_epc     <= 32'd0;
        end else begin
            r_ip <= HWInt;
            if (Req) begin
                r_exl     <= 1'b1;
                r_exccode <= w_int_req ? 5'd0 : ExcCodeIn;
                r_bd      <= BDIn;
                r_epc     <= w_epc_next;
            end else if (EXLClr) begin
                r_exl <= 1'b0;
            end else if (En) begin
                case (CP0Addr)
                    5'd12: begin
                        r_im  <= CP0In[15:10];
                        r_exl <= CP0In[1];
                        r_ie  <= CP0In[0];
                    end
                    5'd14: r_epc <= {CP0In[31:2], 2'b00};
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        CP0Out = 32'd0;
        case (CP0Addr)
            5'd12: CP0Out = {16'd0, r_im, 8'd0, r_exl, r_ie};
            5'd13: CP0Out = {r_bd, 15'd0, r_ip, 3'd0, r_exccode, 2'd0};
            5'd14: CP0Out = r_epc;
            5'd15: CP0Out = PRID;
            default: CP0Out = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_cp0_unit.sv
// tb/tb_cp0_unit.sv - vector/scoreboard bench for cp0_unit
module tb_cp0_unit;

    localparam logic [31:0] PRID = 32'h2023_0001;

    logic        Clk = 1'b0;
    logic        Reset, En, BDIn, EXLClr, Req;
    logic [4:0]  CP0Addr, ExcCodeIn;
    logic [31:0] CP0In, CP0Out, VPC, EPCOut;
    logic [5:0]  HWInt;

    cp0_unit #(.PRID(PRID)) dut (
        .Clk(Clk), .Reset(Reset), .En(En), .CP0Addr(CP0Addr), .CP0In(CP0In),
        .CP0Out(CP0Out), .VPC(VPC), .BDIn(BDIn), .ExcCodeIn(ExcCodeIn),
        .HWInt(HWInt), .EXLClr(EXLClr), .EPCOut(EPCOut), .Req(Req)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic        rst;
        logic        en;
        logic [4:0]  addr;
        logic [31:0] din;
        logic [31:0] vpc;
        logic        bd;
        logic [4:0]  exc;
        logic [5:0]  hw;
        logic        clr;
        logic        exp_req;
        logic [31:0] exp_out;
        logic [31:0] exp_epc;
    } vec_t;

    typedef struct {
        int          idx;
        logic        req;
        logic [31:0] out;
        logic [31:0] epc;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   n_pass  = 0;
    int   n_total = 0;

    function automatic vec_t mk(logic rst, logic en, logic [4:0] addr, logic [31:0] din,
                                logic [31:0] vpc, logic bd, logic [4:0] exc, logic [5:0] hw,
                                logic clr, logic exp_req, logic [31:0] exp_out,
                                logic [31:0] exp_epc);
        vec_t v;
        v.rst = rst; v.en = en; v.addr = addr; v.din = din; v.vpc = vpc; v.bd = bd;
        v.exc = exc; v.hw = hw; v.clr = clr; v.exp_req = exp_req; v.exp_out = exp_out;
        v.exp_epc = exp_epc;
        return v;
    endfunction

    task automatic check32(string name, int idx, logic [31:0] act, logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s[%0d]: got %08h, want %08h", name, idx, act, req);
    endtask

    // Drive one cycle: inputs applied just after posedge, outputs compared at negedge.
    task automatic step(vec_t v, int idx);
        exp_t e;
        exp_t got;
        @(posedge Clk);
        #1;
        Reset = v.rst; En = v.en; CP0Addr = v.addr; CP0In = v.din; VPC = v.vpc;
        BDIn = v.bd; ExcCodeIn = v.exc; HWInt = v.hw; EXLClr = v.clr;
        e.idx = idx; e.req = v.exp_req; e.out = v.exp_out; e.epc = v.exp_epc;
        sb.push_back(e);
        @(negedge Clk);
        got = sb.pop_front();
        check32("Req",    got.idx, {31'd0, Req}, {31'd0, got.req});
        check32("CP0Out", got.idx, CP0Out, got.out);
        check32("EPCOut", got.idx, EPCOut, got.epc);
    endtask

    initial begin
        Reset = 1'b1; En = 1'b0; CP0Addr = 5'd0; CP0In = 32'd0; VPC = 32'd0;
        BDIn = 1'b0; ExcCodeIn = 5'd0; HWInt = 6'd0; EXLClr = 1'b0;
        @(posedge Clk);

        //            rst en addr din           vpc           bd exc  hw        clr req out           epc
        vecs.push_back(mk(0, 0, 12, 32'h0,        32'h0,        0, 0,  6'b000000, 0, 0, 32'h0,        32'h0));
        vecs.push_back(mk(0, 0, 13, 32'h0,        32'h0,        0, 0,  6'b000100, 0, 0, 32'h0,        32'h0));
        vecs.push_back(mk(0, 0, 13, 32'h0,        32'h0,        0, 0,  6'b000000, 0, 0, 32'h0000_1000, 32'h0));
        vecs.push_back(mk(0, 0, 14, 32'h0,        32'h0,        0, 0,  6'b000000, 0, 0, 32'h0,        32'h0));
        vecs.push_back(mk(0, 0, 15, 32'h0,        32'h0,        0, 0,  6'b000000, 0, 0, PRID,         32'h0));
        vecs.push_back(mk(0, 1, 12, 32'h401,      32'h0,        0, 0,  6'b000000, 0, 0, 32'h0,        32'h0));
        vecs.push_back(mk(0, 0, 12, 32'h0,        32'h3010,     0, 0,  6'b000001, 0, 1, 32'h401,      32'h0));
        vecs.push_back(mk(0, 0, 13, 32'h0,        32'h0,        0, 0,  6'b000001, 0, 0, 32'h400,      32'h3010));
        vecs.push_back(mk(0, 0, 12, 32'h0,        32'h0,        0, 0,  6'b000001, 0, 0, 32'h403,      32'h3010));
        vecs.push_back(mk(0, 0, 14, 32'h0,        32'h0,        0, 0,  6'b000001, 1, 0, 32'h3010,     32'h3010));
        vecs.push_back(mk(0, 0, 12, 32'h0,        32'h3100,     0, 0,  6'b000001, 0, 1, 32'h401,      32'h3010));
        vecs.push_back(mk(0, 0, 14, 32'h0,        32'h0,        0, 0,  6'b000000, 1, 0, 32'h3100,     32'h3100));
        vecs.push_back(mk(0, 1, 12, 32'h0,        32'h0,        0, 0,  6'b000000, 0, 0, 32'h401,      32'h3100));
        vecs.push_back(mk(0, 0, 13, 32'h0,        32'h3024,     1, 10, 6'b000000, 0, 1, 32'h0,        32'h3100));
        vecs.push_back(mk(0, 0, 13, 32'h0,        32'h0,        0, 5,  6'b000000, 0, 0, 32'h8000_0028, 32'h3020));
        vecs.push_back(mk(0, 0, 14, 32'h0,        32'h0,        0, 0,  6'b000000, 1, 0, 32'h3020,     32'h3020));
        vecs.push_back(mk(0, 1, 12, 32'h401,      32'h0,        0, 0,  6'b000000, 0, 0, 32'h0,        32'h3020));
        vecs.push_back(mk(0, 1, 14, 32'h1234_5678, 32'h3040,    0, 12, 6'b000001, 0, 1, 32'h3020,     32'h3020));
        vecs.push_back(mk(0, 0, 13, 32'h0,        32'h0,        0, 0,  6'b000000, 0, 0, 32'h400,      32'h3040));
        vecs.push_back(mk(0, 0, 12, 32'h0,        32'h0,        0, 0,  6'b000000, 1, 0, 32'h403,      32'h3040));
        vecs.push_back(mk(0, 1, 14, 32'hABCD_0007, 32'h0,       0, 0,  6'b000000, 0, 0, 32'h3040,     32'h3040));
        vecs.push_back(mk(0, 0, 14, 32'h0,        32'h0,        0, 0,  6'b000000, 0, 0, 32'hABCD_0004, 32'hABCD_0004));
        vecs.push_back(mk(0, 0, 12, 32'h0,        32'h3003,     0, 4,  6'b000000, 0, 1, 32'h401,      32'hABCD_0004));
        vecs.push_back(mk(0, 0, 13, 32'h0,        32'h0,        0, 0,  6'b000000, 0, 0, 32'h10,       32'h3000));
        vecs.push_back(mk(1, 0, 14, 32'h0,        32'h0,        0, 0,  6'b000000, 0, 0, 32'h3000,     32'h3000));
        vecs.push_back(mk(1, 0, 12, 32'h0,        32'h0,        0, 3,  6'b000001, 0, 1, 32'h0,        32'h0));
        vecs.push_back(mk(0, 1, 12, 32'hFFFF_FFFF, 32'h0,       0, 0,  6'b000000, 0, 0, 32'h0,        32'h0));
        vecs.push_back(mk(0, 0, 12, 32'h0,        32'h0,        0, 0,  6'b000000, 0, 0, 32'h0000_FC03, 32'h0));
        vecs.push_back(mk(0, 1, 13, 32'hFFFF_FFFF, 32'h0,       0, 0,  6'b000000, 0, 0, 32'h0,        32'h0));
        vecs.push_back(mk(0, 1, 15, 32'hDEAD_BEEF, 32'h0,       0, 0,  6'b000000, 0, 0, PRID,         32'h0));
        vecs.push_back(mk(0, 0, 13, 32'h0,        32'h0,        0, 0,  6'b000000, 0, 0, 32'h0,        32'h0));
        vecs.push_back(mk(0, 1, 7,  32'hFFFF_FFFF, 32'h0,       0, 0,  6'b000000, 0, 0, 32'h0,        32'h0));
        vecs.push_back(mk(0, 0, 12, 32'h0,        32'h0,        0, 0,  6'b000000, 0, 0, 32'h0000_FC03, 32'h0));

        foreach (vecs[i]) step(vecs[i], i);

        // EXL=1 with an interrupt held: no nesting, then eret, then the interrupt lands.
        for (int k = 0; k < 3; k++)
            step(mk(0, 0, 12, 32'h0, 32'h4004, 1, 0, 6'b100000, 0, 0, 32'h0000_FC03, 32'h0), 100 + k);
        step(mk(0, 0, 12, 32'h0, 32'h4004, 1, 0, 6'b100000, 1, 0, 32'h0000_FC03, 32'h0), 103);
        step(mk(0, 0, 12, 32'h0, 32'h4004, 1, 0, 6'b100000, 0, 1, 32'h0000_FC01, 32'h0), 104);
        step(mk(0, 0, 13, 32'h0, 32'h0,    0, 0, 6'b000000, 0, 0, 32'h8000_8000, 32'h4000), 105);
        step(mk(0, 0, 12, 32'h0, 32'h0,    0, 0, 6'b000000, 0, 0, 32'h0000_FC03, 32'h4000), 106);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/cp0_unit.md
# cp0_unit

Coprocessor-0 exception/interrupt controller for the 5-stage MIPS pipeline. It holds SR, Cause, EPC and PRId, and services mtc0/mfc0 issued from the M stage. It produces the pipeline-wide `Req` flush and the `EPCOut` return address that the stage registers consume: `Req` clears them, and `EPCOut` is loaded into D on `eret`. Exceptions are sampled at the M stage.

## Interface
Parameters:
- `PRID`, default 32'h2023_0001: read-only processor ID returned at register 15.

Ports:
- `Clk`  in  1  clock.
- `Reset`  in  1  synchronous, active-high.
- `En`  in  1  mtc0 write strobe (M stage).
- `CP0Addr`  in  5  register number for mtc0/mfc0.
- `CP0In`  in  32  mtc0 write data.
- `CP0Out`  out  32  mfc0 read data (combinational).
- `VPC`  in  32  PC of the instruction currently in M.
- `BDIn`  in  1  M instruction sits in a branch delay slot.
- `ExcCodeIn`  in  5  exception code of the M instruction; 0 means none.
- `HWInt`  in  6  external interrupt lines, level-sensitive.
- `EXLClr`  in  1  `eret` in M; clears SR.EXL.
- `EPCOut`  out  32  current EPC register value.
- `Req`  out  1  exception/interrupt taken this cycle (combinational).

## Operation
Register fields. Unlisted bits always read 0.
- SR (12): IM=[15:10], EXL=[1], IE=[0].
- Cause (13): BD=[31], IP=[15:10], ExcCode=[6:2].
- EPC (14): 32 bits.
- PRId (15): `PRID`.

Request logic:
- IntReq = IE & !EXL & |(HWInt & IM).
- ExcReq = !EXL & (ExcCodeIn != 0).
- Req = IntReq | ExcReq.

Priority at posedge: Reset > Req > EXLClr > En write.
- **Reset:** SR=0, Cause=0, EPC=0.
- **Req:**
  - EXL<=1.
  - ExcCode <= IntReq ? 0 : ExcCodeIn. Interrupts win over simultaneous exceptions.
  - BD<=BDIn.
  - EPC <= BDIn ? {VPC[31:2],2'b00}-4 : {VPC[31:2],2'b00}.
  - Any concurrent `En` write is discarded, since the faulting or interrupted instruction does not commit.
- **EXLClr (no Req):** EXL<=0. No other state changes.
- **En (no Req):**
  - Addr 12 writes SR bits [15:10],[1],[0] only.
  - Addr 14 writes EPC with CP0In[31:2],2'b00.
  - Addr 13 and 15 are read-only; writes are ignored.
  - Other addresses: no effect.
- **Cause.IP:** loaded with HWInt every cycle, including the Req cycle. Cleared by Reset.
- **CP0Out:** mux on CP0Addr over the current (pre-edge) register values. Unmapped addresses return 0. There is no write-to-read bypass.
- **EPCOut:** equals the EPC register. A same-cycle mtc0 to EPC is visible on the next cycle only; hazard/stall logic covers the mtc0→eret case.

## Timing
- Req and CP0Out are combinational from their inputs in the same cycle. Everything else is registered on the posedge of Clk.
- With EXL=1, Req stays 0 regardless of HWInt or ExcCodeIn. This gives no nesting.
- Cycle after a taken Req: EXL=1, so Req drops even if HWInt is still asserted.
- EXLClr and a pending interrupt in the same cycle:
  - EXL is still 1 during that cycle, so Req=0.
  - The interrupt is taken on the next cycle if still pending.
- Reset asserted mid-handler: EXL=0, EPC=0, and Req is evaluated against the cleared IE=0/IM=0, so only ExcReq can fire.
- Outputs after Reset: CP0Out = 0 for addr 12/13/14 and PRID for addr 15; EPCOut=0; Req = (ExcCodeIn!=0).
- VPC misaligned (AdEL fetch): EPC is aligned down. The original VPC is not preserved.

## Test plan
- **Reset defaults:** Reset=1 for one cycle, then read addresses 12/13/14/15 → 0 / 0 (IP=HWInt) / 0 / PRID; EPCOut=0.
- **Interrupt, non-delay-slot:**
  - Stimulus: mtc0 SR=32'h0000_0401, then HWInt=6'b000001, VPC=32'h0000_3010, BDIn=0.
  - Response: Req=1 the same cycle; next cycle EPC=32'h0000_3010, ExcCode=0, EXL=1, Req=0.
- **Exception in delay slot:**
  - Stimulus: ExcCodeIn=5'd10 (RI), BDIn=1, VPC=32'h0000_3024, IE=0.
  - Response: Req=1; then EPC=32'h0000_3020, Cause=32'h8000_0028 | IP.
- **Priority:**
  - Stimulus: interrupt enabled, ExcCodeIn=5'd12 and an En write of EPC=32'h1234_5678, all in the same cycle.
  - Response: ExcCode=0, EPC=VPC; the write is dropped.
- **eret:**
  - Stimulus: with EXL=1 and HWInt held, assert EXLClr for one cycle.
  - Response: Req=0 in that cycle, EXL=0 after it, Req=1 in the next cycle.
- **Write masking/read-only:**
  - Stimulus: mtc0 SR=32'hFFFF_FFFF.
  - Response: reading SR gives 32'h0000_FC03.
  - Stimulus: mtc0 Cause and PRId with arbitrary data.
  - Response: their values are unchanged.
